fifo_uart_tx: RTL and testbench

//  Downstream drain stage for the byte fifo. Pops one byte at a time while the

---
 rtl/fifo_uart_tx_if.sv | 29 ++
 rtl/fifo_uart_tx.sv | 113 +++++++++++
 tb/tb_fifo_uart_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the byte fifo, the UART drain stage and the serial line.
// Handshake: fifo_read_en is a one-cycle pop strobe raised only while fifo_empty is low;
// fifo_data carries the popped byte on the cycle after the strobe and no ready/back-pressure exists.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_read_en,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read_en,
    output tx,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the byte fifo one entry at a time and serialises each byte as an 8N1 UART
// frame (optional even parity). The line idles high whenever there is nothing to send.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_uart_tx_if.slave        bus,
  output logic [2:0]           dbg_state_o
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  // The baud counter restarts at every state change, so each bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) state_d = S_LATCH;
      end
      S_LATCH: begin
        shreg_d   = bus.fifo_data;
        par_d     = ^bus.fifo_data;
        bit_idx_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
        else         cnt_d   = cnt_q + 1'b1;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
        else         cnt_d   = cnt_q + 1'b1;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
        else         cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered from the upcoming state so the line changes on the same edge as the FSM.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.fifo_read_en = (state_q == S_IDLE) && !bus.fifo_empty && !rst;
  assign bus.tx           = tx_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.frame_done   = (state_q == S_STOP) && bit_end;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one lane without parity and one with parity, fed the same byte stream
// from a fifo model; a per-lane monitor decodes the serial line against an expected-byte queue.
module tb_fifo_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [7:0] stim_mem [0:255];
  int         wr_ptr = 0;
  logic       end_phase = 1'b0;
  logic [1:0] tx_w, busy_w, rd_w, fd_w, empty_w;
  logic [2:0] st_w [2];

  task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s lane%0d: got %0h expected %0h (t=%0t)", name, lane, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    stim_mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(empty_w == 2'b11 && busy_w == 2'b00) && n < budget);
    check("drain_done", 0, {empty_w, busy_w}, 4'b1100);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam bit PAR = (g == 1);
    localparam int NB  = PAR ? 11 : 10;

    fifo_uart_tx_if bus();
    logic [2:0] dbg_state;
    logic [7:0] data_q = 8'h00;
    logic [7:0] exp_q[$];
    int         rd_ptr = 0;
    int         exp_wr = 0;
    int         rd_cnt = 0;
    int         frames = 0;
    int         aborts = 0;
    logic       prev_rd = 1'b0;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(PAR)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
    );

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_data  = data_q;
    assign tx_w[g]        = bus.tx;
    assign busy_w[g]      = bus.busy;
    assign rd_w[g]        = bus.fifo_read_en;
    assign fd_w[g]        = bus.frame_done;
    assign empty_w[g]     = bus.fifo_empty;
    assign st_w[g]        = dbg_state;

    // fifo model: data appears the cycle after the read strobe
    always @(posedge clk) begin
      if (bus.fifo_read_en && rd_ptr < wr_ptr) begin
        data_q <= stim_mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end

    always @(negedge clk) begin
      while (exp_wr < wr_ptr) begin
        exp_q.push_back(stim_mem[exp_wr[7:0]]);
        exp_wr++;
      end
    end

    always @(negedge clk) begin
      if (bus.fifo_read_en) begin
        rd_cnt++;
        check("read_en_single_and_idle", g, {30'b0, prev_rd, bus.busy}, 0);
      end
      prev_rd = bus.fifo_read_en;
    end

    // expected line level k cycles after the start edge
    function automatic logic exp_level(input logic [7:0] b, input int k);
      int j;
      j = k / C;
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (PAR && j == 9) return ^b;
      return 1'b1;
    endfunction

    initial begin : monitor
      int         gap;
      bit         gap_armed;
      bit         aborted;
      int         bad_k;
      int         j;
      logic [7:0] e;
      logic [7:0] rx;
      logic       bit9;
      gap = 0;
      gap_armed = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          gap = 0;
          gap_armed = 0;
        end else if (bus.tx !== 1'b0) begin
          gap++;
          if (bus.frame_done !== 1'b0) check("frame_done_outside_frame", g, bus.frame_done, 0);
        end else begin
          if (gap_armed) check("frame_gap", g, gap, 2);
          gap_armed = 0;
          e = 8'h00;
          if (exp_q.size() == 0) check("exp_q_nonempty_at_start", g, exp_q.size(), 1);
          else e = exp_q.pop_front();
          aborted = 0;
          bad_k = -1;
          rx = 8'h00;
          bit9 = 1'b0;
          for (int k = 0; k < NB * C; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin
              aborted = 1;
              break;
            end
            if (bad_k < 0 && (bus.tx !== exp_level(e, k) || bus.busy !== 1'b1 ||
                              bus.frame_done !== (k == NB * C - 1)))
              bad_k = k;
            if (k % C == C / 2) begin
              j = k / C;
              if (j >= 1 && j <= 8) rx[j-1] = bus.tx;
              if (j == 9) bit9 = bus.tx;
            end
          end
          if (aborted) begin
            aborts++;
            gap = 0;
          end else begin
            frames++;
            check("frame_data", g, rx, e);
            check("frame_first_bad_cycle", g, bad_k, -1);
            check("bit9_parity_or_stop", g, bit9, PAR ? ^e : 1'b1);
            @(negedge clk);
            if (!rst) begin
              check("idle_after_frame", g, {bus.busy, bus.tx}, 2'b01);
              gap = 1;
              gap_armed = !bus.fifo_empty;
            end
          end
        end
      end
    end

    initial begin
      wait (end_phase);
      check("read_count", g, rd_cnt, wr_ptr);
      check("frame_count", g, frames, wr_ptr - 1);
      check("abort_count", g, aborts, 1);
      check("exp_q_left", g, exp_q.size(), 0);
    end
  end

  initial begin : main
    int bad;
    int n;
    #1 rst = 1'b1;
    push_byte(8'hA5);
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("reset_outputs", i, {tx_w[i], busy_w[i], rd_w[i], fd_w[i]}, 4'b1000);
        check("reset_state", i, st_w[i], 0);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("first_read_after_release", i, rd_w[i], 1);
    wait_idle(2000);

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 255)));
    wait_idle(5000);

    @(posedge clk);
    #1;
    push_byte(8'h07);
    push_byte(8'h03);
    wait_idle(2000);

    // abort 8'h3C in the middle of data bit 3; 8'h5A must follow it
    @(posedge clk);
    #1;
    push_byte(8'h3C);
    push_byte(8'h5A);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_w[0] !== 1'b0 && n < 20);
    check("start_seen_before_abort", 0, tx_w[0], 0);
    repeat (4 * C + 1) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check("async_reset_outputs", i, {tx_w[i], busy_w[i]}, 2'b10);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(2000);

    bad = 0;
    repeat (200) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if ({tx_w[i], busy_w[i], rd_w[i]} !== 3'b100) bad++;
    end
    check("empty_fifo_idle_hold", 0, bad, 0);

    repeat (20) begin
      repeat ($urandom_range(0, 60)) @(posedge clk);
      #1 push_byte(8'($urandom_range(0, 255)));
    end
    wait_idle(6000);

    end_phase = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
